// File: rtl/mega_regs_wb_arb_if.sv
// rtl/mega_regs_wb_arb_if.sv - write-port request/response bundle between core sources and the register-file arbiter
//
// Purpose: groups the three write sources and the register-file write port.
// The ALU source is alu_we/wa/wm/wd, with alu_stall returned.
// The load source is ld_req/wa/wm/wd, with ld_ack returned.
// The debug source is dbg_req/wa/wm/wd, with dbg_ack returned.
// The register-file write port is rda/rd/rdw/rdm.
// busy and err_alu_override report status.
// master: core/LSU/debug side (drives requests).
// slave: arbiter side (drives write port, acks, status).
interface mega_regs_wb_arb_if;
    logic        alu_we;
    logic [4:0]  alu_wa;
    logic        alu_wm;
    logic [15:0] alu_wd;
    logic        alu_stall;
    logic        ld_req;
    logic [4:0]  ld_wa;
    logic        ld_wm;
    logic [15:0] ld_wd;
    logic        ld_ack;
    logic        dbg_req;
    logic [4:0]  dbg_wa;
    logic        dbg_wm;
    logic [15:0] dbg_wd;
    logic        dbg_ack;
    logic [4:0]  rda;
    logic [15:0] rd;
    logic        rdw;
    logic        rdm;
    logic        busy;
    logic        err_alu_override;

    modport master (
        output alu_we, alu_wa, alu_wm, alu_wd,
        output ld_req, ld_wa, ld_wm, ld_wd,
        output dbg_req, dbg_wa, dbg_wm, dbg_wd,
        input  alu_stall, ld_ack, dbg_ack,
        input  rda, rd, rdw, rdm, busy, err_alu_override
    );

    modport slave (
        input  alu_we, alu_wa, alu_wm, alu_wd,
        input  ld_req, ld_wa, ld_wm, ld_wd,
        input  dbg_req, dbg_wa, dbg_wm, dbg_wd,
        output alu_stall, ld_ack, dbg_ack,
        output rda, rd, rdw, rdm, busy, err_alu_override
    );
endinterface

// File: rtl/mega_regs_wb_arb.sv
// rtl/mega_regs_wb_arb.sv - register-file write-port arbiter with post-reset zero-fill and load starvation control
//
// Purpose: shares the single 32x8 register-file write port among three sources.
// Fixed priority is ALU > load > debug.
// After reset, zero-fills the file with 16 word writes.
// Ports:
//   clk - core clock.
//   rst - asynchronous active-low reset.
//   bus - mega_regs_wb_arb_if.slave, carrying the requests, the write port and the status.
module mega_regs_wb_arb #(
    parameter string CLEAR_ON_RESET = "TRUE",
    parameter int    STARVE_LIMIT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mega_regs_wb_arb_if.slave        bus
);
    localparam bit         CLR_EN = (CLEAR_ON_RESET == "TRUE");
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t      state_q, state_d;
    // Bit 4 marks the extra idle cycle after pair 15, where busy drops with rdw=0.
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [4:0]  rda_q, rda_d;
    logic [15:0] rd_q, rd_d;
    logic        rdw_q, rdw_d;
    logic        rdm_q, rdm_d;
    logic        ld_ack_q, ld_ack_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic        alu_stall_q, alu_stall_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        ld_elig, dbg_elig;
    logic        grant_alu, grant_ld, grant_dbg;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        starve_cnt_d = starve_cnt_q;
        rda_d        = rda_q;
        rd_d         = rd_q;
        rdm_d        = rdm_q;
        rdw_d        = 1'b0;
        ld_ack_d     = 1'b0;
        dbg_ack_d    = 1'b0;
        alu_stall_d  = alu_stall_q;
        busy_d       = busy_q;
        err_d        = err_q;
        // A request whose ack is showing this cycle is the one just written;
        // skipping it lets the requester drop req without a double write.
        ld_elig      = bus.ld_req && !ld_ack_q;
        dbg_elig     = bus.dbg_req && !dbg_ack_q;
        grant_alu    = 1'b0;
        grant_ld     = 1'b0;
        grant_dbg    = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                if (clr_cnt_q[4]) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b0;
                    clr_cnt_d = '0;
                end else begin
                    rdw_d     = 1'b1;
                    rdm_d     = 1'b1;
                    rda_d     = {1'b0, clr_cnt_q[3:0]};
                    rd_d      = '0;
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
            S_RUN: begin
                grant_alu = bus.alu_we;
                grant_ld  = !grant_alu && ld_elig;
                grant_dbg = !grant_alu && !grant_ld && dbg_elig;

                if (grant_alu) begin
                    rdw_d = 1'b1;
                    rda_d = bus.alu_wa;
                    rdm_d = bus.alu_wm;
                    rd_d  = bus.alu_wd;
                end else if (grant_ld) begin
                    rdw_d    = 1'b1;
                    rda_d    = bus.ld_wa;
                    rdm_d    = bus.ld_wm;
                    rd_d     = bus.ld_wd;
                    ld_ack_d = 1'b1;
                end else if (grant_dbg) begin
                    rdw_d     = 1'b1;
                    rda_d     = bus.dbg_wa;
                    rdm_d     = bus.dbg_wm;
                    rd_d      = bus.dbg_wd;
                    dbg_ack_d = 1'b1;
                end

                // Saturating so a long stall cannot wrap the counter below the limit.
                if (grant_ld || !bus.ld_req) begin
                    starve_cnt_d = '0;
                end else if (ld_elig && (starve_cnt_q != 4'hF)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end

                if (ld_ack_q) begin
                    alu_stall_d = 1'b0;
                end else if (starve_cnt_q >= LIMIT) begin
                    alu_stall_d = 1'b1;
                end

                // The ALU write still wins; we only record that the core ignored the stall.
                if (bus.alu_we && alu_stall_q) begin
                    err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CLR_EN ? S_CLEAR : S_RUN;
            clr_cnt_q    <= '0;
            starve_cnt_q <= '0;
            rda_q        <= '0;
            rd_q         <= '0;
            rdw_q        <= 1'b0;
            rdm_q        <= 1'b0;
            ld_ack_q     <= 1'b0;
            dbg_ack_q    <= 1'b0;
            alu_stall_q  <= 1'b0;
            busy_q       <= CLR_EN;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rda_q        <= rda_d;
            rd_q         <= rd_d;
            rdw_q        <= rdw_d;
            rdm_q        <= rdm_d;
            ld_ack_q     <= ld_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            alu_stall_q  <= alu_stall_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign bus.rda              = rda_q;
    assign bus.rd               = rd_q;
    assign bus.rdw              = rdw_q;
    assign bus.rdm              = rdm_q;
    assign bus.ld_ack           = ld_ack_q;
    assign bus.dbg_ack          = dbg_ack_q;
    assign bus.alu_stall        = alu_stall_q;
    assign bus.busy             = busy_q;
    assign bus.err_alu_override = err_q;
endmodule

// File: tb/tb_mega_regs_wb_arb.sv
// tb/tb_mega_regs_wb_arb.sv - scoreboard bench for mega_regs_wb_arb
module tb_mega_regs_wb_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mega_regs_wb_arb_if bus();

    mega_regs_wb_arb #(.CLEAR_ON_RESET("TRUE"), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [21:0] wq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] wr(input logic [4:0] a, input logic m, input logic [15:0] d);
        return {a, m, d};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && bus.rdw) begin
            check("sb_pending", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                check("sb_write", 32'({bus.rda, bus.rdm, bus.rd}), 32'(wq.pop_front()));
            end
        end
    end

    task automatic fill_phase(input string tag);
        int fill_wr;
        logic ack_seen;
        fill_wr  = 0;
        ack_seen = 1'b0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            tick();
            if (bus.busy && bus.rdw && bus.rdm) fill_wr++;
            ack_seen |= bus.ld_ack;
        end
        check({tag, "_count"}, 32'(fill_wr), 32'd16);
        check({tag, "_noack"}, 32'(ack_seen), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_end_rdw"}, 32'(bus.rdw), 32'd0);
    endtask

    task automatic push_fill();
        for (int i = 0; i < 16; i++) wq.push_back(wr(5'(i), 1'b1, 16'h0000));
    endtask

    task automatic starve(input bit ovr, input logic [15:0] ldd);
        int cyc;
        cyc = 0;
        bus.ld_req = 1'b1; bus.ld_wa = 5'd20; bus.ld_wm = 1'b0; bus.ld_wd = ldd;
        for (int i = 0; i < 20; i++) begin
            bus.alu_we = 1'b1; bus.alu_wa = 5'(i); bus.alu_wm = 1'b1;
            bus.alu_wd = 16'(32'hA000 + i);
            wq.push_back(wr(bus.alu_wa, 1'b1, bus.alu_wd));
            tick();
            cyc++;
            if (bus.alu_stall) break;
        end
        check("stall_rise", 32'(cyc), 32'd5);
        if (ovr) begin
            bus.alu_wa = 5'd30; bus.alu_wm = 1'b0; bus.alu_wd = 16'h0BAD;
            wq.push_back(wr(5'd30, 1'b0, 16'h0BAD));
            tick();
            check("ovr_err", 32'(bus.err_alu_override), 32'd1);
            check("ovr_noack", 32'(bus.ld_ack), 32'd0);
        end else begin
            check("no_ovr_err", 32'(bus.err_alu_override), 32'd0);
        end
        bus.alu_we = 1'b0;
        wq.push_back(wr(5'd20, 1'b0, ldd));
        tick();
        check("starve_ack", 32'(bus.ld_ack), 32'd1);
        check("stall_held", 32'(bus.alu_stall), 32'd1);
        bus.ld_req = 1'b0;
        tick();
        check("stall_clr", 32'(bus.alu_stall), 32'd0);
        check("starve_ack_end", 32'(bus.ld_ack), 32'd0);
    endtask

    initial begin
        bus.alu_we = 1'b0; bus.alu_wa = '0; bus.alu_wm = 1'b0; bus.alu_wd = '0;
        bus.ld_req = 1'b0; bus.ld_wa = '0; bus.ld_wm = 1'b0; bus.ld_wd = '0;
        bus.dbg_req = 1'b0; bus.dbg_wa = '0; bus.dbg_wm = 1'b0; bus.dbg_wd = '0;

        tick();
        check("rst_rda", 32'(bus.rda), 32'd0);
        check("rst_rd", 32'(bus.rd), 32'd0);
        check("rst_rdw", 32'(bus.rdw), 32'd0);
        check("rst_rdm", 32'(bus.rdm), 32'd0);
        check("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
        check("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
        check("rst_stall", 32'(bus.alu_stall), 32'd0);
        check("rst_err", 32'(bus.err_alu_override), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);

        // Load held through the fill, then handshake with no contention.
        push_fill();
        bus.ld_req = 1'b1; bus.ld_wa = 5'd24; bus.ld_wm = 1'b1; bus.ld_wd = 16'hBEEF;
        wq.push_back(wr(5'd24, 1'b1, 16'hBEEF));
        #2 rst = 1'b1;
        fill_phase("fill");
        tick();
        check("ld_ack_pulse", 32'(bus.ld_ack), 32'd1);
        tick();
        check("ld_no_double_ack", 32'(bus.ld_ack), 32'd0);
        check("ld_no_double_wr", 32'(bus.rdw), 32'd0);
        bus.ld_req = 1'b0;
        tick();

        // Priority: all three in one cycle.
        bus.alu_we = 1'b1; bus.alu_wa = 5'd3; bus.alu_wm = 1'b0; bus.alu_wd = 16'h00AA;
        bus.ld_req = 1'b1; bus.ld_wa = 5'd7; bus.ld_wm = 1'b1; bus.ld_wd = 16'h1234;
        bus.dbg_req = 1'b1; bus.dbg_wa = 5'd9; bus.dbg_wm = 1'b0; bus.dbg_wd = 16'h0055;
        wq.push_back(wr(5'd3, 1'b0, 16'h00AA));
        wq.push_back(wr(5'd7, 1'b1, 16'h1234));
        wq.push_back(wr(5'd9, 1'b0, 16'h0055));
        tick();
        check("prio_alu_no_ld_ack", 32'(bus.ld_ack), 32'd0);
        check("prio_alu_no_dbg_ack", 32'(bus.dbg_ack), 32'd0);
        bus.alu_we = 1'b0;
        tick();
        check("prio_ld_ack", 32'(bus.ld_ack), 32'd1);
        check("prio_ld_no_dbg", 32'(bus.dbg_ack), 32'd0);
        bus.ld_req = 1'b0;
        tick();
        check("prio_dbg_ack", 32'(bus.dbg_ack), 32'd1);
        bus.dbg_req = 1'b0;
        tick();
        check("prio_idle_rdw", 32'(bus.rdw), 32'd0);
        check("hold_rda", 32'(bus.rda), 32'd9);
        check("hold_rd", 32'(bus.rd), 32'h0055);

        starve(1'b0, 16'h5A5A);
        tick();
        starve(1'b1, 16'hC3C3);
        tick();
        tick();
        check("err_sticky", 32'(bus.err_alu_override), 32'd1);

        // Async reset right after a load grant.
        bus.ld_req = 1'b1; bus.ld_wa = 5'd11; bus.ld_wm = 1'b1; bus.ld_wd = 16'hCAFE;
        wq.push_back(wr(5'd11, 1'b1, 16'hCAFE));
        tick();
        check("rst_pre_ack", 32'(bus.ld_ack), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_ld_ack", 32'(bus.ld_ack), 32'd0);
        check("arst_rdw", 32'(bus.rdw), 32'd0);
        check("arst_rda", 32'(bus.rda), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd1);
        check("arst_err", 32'(bus.err_alu_override), 32'd0);
        push_fill();
        wq.push_back(wr(5'd11, 1'b1, 16'hCAFE));
        tick();
        #2 rst = 1'b1;
        fill_phase("refill");
        tick();
        check("rst_post_ack", 32'(bus.ld_ack), 32'd1);
        bus.ld_req = 1'b0;
        tick();
        tick();
        check("sb_empty", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mega_regs_wb_arb.md
Name: mega_regs_wb_arb

Overview:
- Arbiter and sequencer for the write port of the 32 x 8 CPU register file (rda/rd/rdw/rdm).
- Shares the single write port among three sources: ALU writeback, load/pop writeback and debug writes.
- After reset, zero-fills the file with word writes before the core runs.
- Bounds load-writeback starvation by stalling the ALU.
- Sits between the core pipeline/LSU/debug unit and the register file; read ports are untouched.

Parameters:
CLEAR_ON_RESET, "TRUE", "TRUE" runs the 16-cycle zero-fill after reset; "FALSE" enters RUN directly.
STARVE_LIMIT, 4, consecutive cycles a pending load may lose to the ALU before alu_stall asserts (1..15).

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
alu_we  in  1  ALU writeback valid (single-cycle, no handshake)
alu_wa  in  5  ALU destination address
alu_wm  in  1  ALU word mode (1 = 16-bit pair write)
alu_wd  in  16  ALU write data
alu_stall  out  1  core must not assert alu_we next cycle
ld_req  in  1  load writeback request, held with data until ld_ack
ld_wa  in  5  load destination
ld_wm  in  1  load word mode
ld_wd  in  16  load data
ld_ack  out  1  one-cycle pulse: load request written
dbg_req  in  1  debug write request, held until dbg_ack
dbg_wa  in  5  debug destination
dbg_wm  in  1  debug word mode
dbg_wd  in  16  debug data
dbg_ack  out  1  one-cycle pulse: debug request written
rda  out  5  register file write address
rd  out  16  register file write data
rdw  out  1  register file write enable
rdm  out  1  register file word mode
busy  out  1  zero-fill in progress
err_alu_override  out  1  sticky: alu_we seen while alu_stall high

Behaviour:
- All outputs registered. Reset values: rda=0, rd=0, rdw=0, rdm=0, ld_ack=0, dbg_ack=0, alu_stall=0, err_alu_override=0. busy=1 if CLEAR_ON_RESET="TRUE", else 0.
- States: CLEAR, RUN. Reset enters CLEAR when CLEAR_ON_RESET="TRUE", else RUN.
- CLEAR:
  - 4-bit clr_cnt from 0. Each cycle drives rdw=1, rdm=1, rda={1'b0,clr_cnt}, rd=0.
  - After clr_cnt=15 is driven: next cycle busy=0, rdw=0, state RUN.
  - All requests are ignored in CLEAR: no acks, alu_we dropped.
- RUN, one grant per cycle by fixed priority ALU > load > debug:
  - Write outputs appear the cycle after the inputs are sampled (latency 1).
  - Granted source's {wa, wm, wd} drive {rda, rdm, rd} with rdw=1. With no grant, rdw=0 and rda/rd/rdm hold their last values.
  - The grant also sets that source's ack in the same registered cycle.
  - A request whose ack is high in the current cycle is ignored, so a requester seeing ack and dropping req next cycle is not granted twice.
  - Back-to-back grants to the same requester are therefore at most every other cycle.
- Starvation control:
  - starve_cnt increments each RUN cycle in which ld_req is eligible and not granted; it clears when ld_ack is issued or ld_req is low.
  - When starve_cnt reaches STARVE_LIMIT, alu_stall goes 1 on the next edge and stays 1 until the ld_ack cycle; it clears on the edge after ld_ack.
  - If alu_we arrives while alu_stall=1, the ALU still wins (data is never lost), err_alu_override sets, and it clears only on reset.
- Debug has no starvation guarantee.
- Reset mid-operation: asynchronous return to reset values; an in-flight ack is lost and the requester must keep req asserted. The zero-fill restarts from pair 0.
- Byte writes (wm=0) pass rda unchanged; the register file handles lane select.

Test Plan:
- Zero-fill: release rst with CLEAR_ON_RESET="TRUE" → 16 cycles of rdw=1, rdm=1, rda=0..15, rd=0. busy falls the cycle after rda=15. ld_req held during fill gets ld_ack only after busy=0.
- Priority: alu_we, ld_req and dbg_req all high in one cycle with alu_wa=5'd3, alu_wd=16'h00AA → next cycle rda=3, rd=16'h00AA, no acks. Then load is granted, then debug, two cycles later.
- Handshake: ld_req held with ld_wa=24, ld_wm=1, ld_wd=16'hBEEF, no contention → exactly one rdw pulse with rda=24, rdm=1, rd=16'hBEEF and one ld_ack pulse. With req held through the ack cycle, no second write.
- Starvation: STARVE_LIMIT=4, alu_we continuous, ld_req held → alu_stall rises after 4 lost cycles. Once alu_we drops, the load is written and alu_stall clears the cycle after ld_ack.
- Override: drive alu_we while alu_stall=1 → ALU write occurs, err_alu_override=1 and stays set until rst low.
- Async reset during load grant: assert rst low mid-cycle → all outputs at reset values immediately. After release the zero-fill repeats from pair 0.
